// File: rtl/bp_pkg.sv
// Shared types for the gshare scheduler: 2-bit counter encodings, FSM states
// and the saturating counter update.
package bp_pkg;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] r;
      if (taken) r = (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
      else       r = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
      return r;
   endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order FIFO of predicted-but-unresolved branches; flush empties it and
// overrides a same-cycle push.
module bp_inflight_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, rd_q;

   // Extra pointer bit distinguishes full from empty when the low bits match.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign rdata = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push && !full)  wr_q <= wr_q + 1'b1;
         if (pop  && !empty) rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush && push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/gshare_sched_ctrl.sv
// gshare PHT sequencer: owns the GHR, arbitrates the single PHT port between
// lookups and resolves, recovers GHR on mispredict. GSHARE_STATS_EN adds counters.
module gshare_sched_ctrl
   import bp_pkg::*;
#(
   parameter int PC_W  = 11,
   parameter int IDX_W = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lk_valid,
   output logic             lk_ready,
   input  logic [PC_W-1:0]  lk_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             rs_valid,
   output logic             rs_ready,
   input  logic             rs_taken,
   output logic             mispredict,
   output logic             pht_en,
   output logic             pht_we,
   output logic [IDX_W-1:0] pht_idx,
   output logic [1:0]       pht_wdata,
   input  logic [1:0]       pht_rdata,
   output logic             busy
`ifdef GSHARE_STATS_EN
   ,
   output logic [31:0]      stat_lookups,
   output logic [31:0]      stat_mispred
`endif
);

   localparam int EW = 2*IDX_W + 3;

   state_e           state_q;
   logic [IDX_W-1:0] sweep_q, ghr_q, lk_idx_q;
   logic             mispredict_q;

   logic             full, empty, run, lk_fire, rs_fire, rs_mis, push;
   logic [IDX_W-1:0] lk_idx, hd_idx, hd_ghr;
   logic [1:0]       hd_ctr;
   logic             hd_pred;
   logic [EW-1:0]    push_data, hd_data;
   logic             unused_pc;

   assign unused_pc = ^lk_pc[PC_W-1:IDX_W];

   assign run      = (state_q == ST_RUN);
   assign rs_ready = run && !empty;
   assign lk_ready = run && !full && !(rs_valid && !empty);
   assign rs_fire  = rs_valid && rs_ready;
   assign lk_fire  = lk_valid && lk_ready;
   assign lk_idx   = lk_pc[IDX_W-1:0] ^ ghr_q;
   assign rs_mis   = rs_fire && (rs_taken != hd_pred);

   assign busy       = (state_q == ST_INIT);
   assign pred_valid = (state_q == ST_RESP);
   assign pred_taken = (state_q == ST_RESP) && pht_rdata[1];
   assign mispredict = mispredict_q;

   // The read data arrives during RESP; the entry is captured then, with the
   // GHR value that formed its index.
   assign push      = (state_q == ST_RESP);
   assign push_data = {lk_idx_q, pht_rdata, pht_rdata[1], ghr_q};
   assign {hd_idx, hd_ctr, hd_pred, hd_ghr} = hd_data;

   bp_inflight_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (rs_fire),
      .flush (rs_mis),
      .wdata (push_data),
      .rdata (hd_data),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      pht_en    = 1'b0;
      pht_we    = 1'b0;
      pht_idx   = '0;
      pht_wdata = 2'b00;
      if (state_q == ST_INIT) begin
         pht_en    = 1'b1;
         pht_we    = 1'b1;
         pht_idx   = sweep_q;
         pht_wdata = CTR_WNT;
      end else if (rs_fire) begin
         // Stored counter may be stale if an older branch hit the same index.
         pht_en    = 1'b1;
         pht_we    = 1'b1;
         pht_idx   = hd_idx;
         pht_wdata = sat_update(hd_ctr, rs_taken);
      end else if (lk_fire) begin
         pht_en  = 1'b1;
         pht_idx = lk_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_INIT;
         sweep_q      <= '0;
         ghr_q        <= '0;
         lk_idx_q     <= '0;
         mispredict_q <= 1'b0;
      end else begin
         mispredict_q <= rs_mis;
         case (state_q)
            ST_INIT: begin
               sweep_q <= sweep_q + 1'b1;
               if (sweep_q == {IDX_W{1'b1}}) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (rs_mis) ghr_q <= {hd_ghr[IDX_W-2:0], rs_taken};
               if (lk_fire) begin
                  lk_idx_q <= lk_idx;
                  state_q  <= ST_RESP;
               end
            end
            ST_RESP: begin
               ghr_q   <= {ghr_q[IDX_W-2:0], pht_rdata[1]};
               state_q <= ST_RUN;
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

`ifdef GSHARE_STATS_EN
   logic [31:0] lookups_q, mispred_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         lookups_q <= '0;
         mispred_q <= '0;
      end else begin
         if (lk_fire) lookups_q <= lookups_q + 32'd1;
         if (rs_mis)  mispred_q <= mispred_q + 32'd1;
      end
   end

   assign stat_lookups = lookups_q;
   assign stat_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_gshare_sched_ctrl.sv
// Randomized bench for gshare_sched_ctrl with an owned PHT RAM and a queue-based
// reference model of in-flight branches, GHR and counter table.
module tb_gshare_sched_ctrl;

   localparam int PC_W = 11, IDX_W = 4, DEPTH = 4, N = 16;

   logic clk = 1'b0, reset = 1'b1;
   logic lk_valid = 1'b0, rs_valid = 1'b0, rs_taken = 1'b0;
   logic [PC_W-1:0] lk_pc = '0;
   logic lk_ready, pred_valid, pred_taken, rs_ready, mispredict, pht_en, pht_we, busy;
   logic [IDX_W-1:0] pht_idx;
   logic [1:0] pht_wdata;
   logic [1:0] pht_rdata = 2'b00;
`ifdef GSHARE_STATS_EN
   logic [31:0] stat_lookups, stat_mispred;
`endif

   gshare_sched_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_pc(lk_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_taken(rs_taken),
      .mispredict(mispredict),
      .pht_en(pht_en), .pht_we(pht_we), .pht_idx(pht_idx),
      .pht_wdata(pht_wdata), .pht_rdata(pht_rdata),
      .busy(busy)
`ifdef GSHARE_STATS_EN
      , .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   // PHT RAM owned by the bench; preload lets directed cases seed counters.
   logic [1:0] ram [N];
   logic [1:0] pre_vals [N];
   logic pre_en = 1'b0;

   always @(posedge clk) begin
      if (pre_en) begin
         for (int i = 0; i < N; i++) ram[i] <= pre_vals[i];
      end else if (pht_en) begin
         if (pht_we) ram[pht_idx] <= pht_wdata;
         else        pht_rdata    <= ram[pht_idx];
      end
   end

   typedef struct {
      logic [3:0] idx;
      logic [1:0] ctr;
      logic       pred;
      logic [3:0] ghr;
   } ent_t;

   int n_vec = 0, n_err = 0;

   // reference model state
   int         init_cnt;
   bit         resp_pend, misp_pend;
   logic [3:0] resp_idx, m_ghr;
   logic [1:0] resp_ctr;
   logic [1:0] mram [N];
   ent_t       q[$];
   int         m_lookups, m_mispred;

   // outputs sampled by the last step
   logic       s_busy, s_we, s_pred_taken, s_misp, s_lk_ready, s_rs_ready;
   logic [3:0] s_idx;
   logic [1:0] s_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
      int v;
      v = int'(c) + (t ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   // Called at a negedge: drive, check against the model, advance the model.
   task automatic step(input logic lv, input logic [PC_W-1:0] pc, input logic rv, input logic rt);
      logic e_busy, e_en, e_we, e_pv, e_pt, e_lr, e_rr;
      logic [3:0] e_idx;
      logic [1:0] e_wd;
      bit lk_go, rs_go;
      ent_t h;
      lk_valid = lv; lk_pc = pc; rs_valid = rv; rs_taken = rt;
      #1;
      e_busy = (init_cnt < N);
      {e_en, e_we, e_pv, e_pt, e_lr, e_rr} = '0;
      e_idx = '0; e_wd = '0; lk_go = 0; rs_go = 0;
      if (e_busy) begin
         e_en = 1; e_we = 1; e_idx = 4'(init_cnt); e_wd = 2'b01;
      end else if (resp_pend) begin
         e_pv = 1; e_pt = resp_ctr[1];
      end else begin
         e_rr  = (q.size() != 0);
         e_lr  = (q.size() < DEPTH) && !(rv && q.size() != 0);
         rs_go = rv && e_rr;
         lk_go = lv && e_lr;
         if (rs_go) begin
            h = q[0];
            e_en = 1; e_we = 1; e_idx = h.idx; e_wd = sat(h.ctr, rt);
         end else if (lk_go) begin
            e_en = 1; e_idx = pc[3:0] ^ m_ghr;
         end
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("pht_en", 32'(pht_en), 32'(e_en));
      chk("pht_we", 32'(pht_we), 32'(e_we));
      if (e_en) chk("pht_idx", 32'(pht_idx), 32'(e_idx));
      if (e_we) chk("pht_wdata", 32'(pht_wdata), 32'(e_wd));
      chk("pred_valid", 32'(pred_valid), 32'(e_pv));
      chk("pred_taken", 32'(pred_taken), 32'(e_pt));
      chk("mispredict", 32'(mispredict), 32'(misp_pend));
      chk("lk_ready", 32'(lk_ready), 32'(e_lr));
      chk("rs_ready", 32'(rs_ready), 32'(e_rr));
`ifdef GSHARE_STATS_EN
      chk("stat_lookups", stat_lookups, 32'(m_lookups));
      chk("stat_mispred", stat_mispred, 32'(m_mispred));
`endif
      s_busy = busy; s_we = pht_we; s_pred_taken = pred_taken; s_misp = mispredict;
      s_lk_ready = lk_ready; s_rs_ready = rs_ready; s_idx = pht_idx; s_wdata = pht_wdata;

      misp_pend = 0;
      if (e_busy) begin
         mram[init_cnt] = 2'b01;
         init_cnt++;
      end else if (resp_pend) begin
         q.push_back('{resp_idx, resp_ctr, resp_ctr[1], m_ghr});
         m_ghr = {m_ghr[2:0], resp_ctr[1]};
         resp_pend = 0;
      end else if (rs_go) begin
         h = q.pop_front();
         mram[h.idx] = sat(h.ctr, rt);
         if (rt != h.pred) begin
            q.delete();
            m_ghr = {h.ghr[2:0], rt};
            misp_pend = 1;
            m_mispred++;
         end
      end else if (lk_go) begin
         resp_pend = 1;
         resp_idx  = e_idx;
         resp_ctr  = mram[e_idx];
         m_lookups++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; lk_valid = 1'b0; rs_valid = 1'b0;
      @(negedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_pht_en", 32'(pht_en), 32'd1);
      chk("rst_pht_we", 32'(pht_we), 32'd1);
      chk("rst_pht_idx", 32'(pht_idx), 32'd0);
      chk("rst_pred_valid", 32'(pred_valid), 32'd0);
      chk("rst_mispredict", 32'(mispredict), 32'd0);
      chk("rst_lk_ready", 32'(lk_ready), 32'd0);
      chk("rst_rs_ready", 32'(rs_ready), 32'd0);
      reset = 1'b0;
      init_cnt = 0; resp_pend = 0; misp_pend = 0; m_ghr = '0; q.delete();
      m_lookups = 0; m_mispred = 0;
   endtask

   task automatic run_init();
      int nb = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         if (!s_busy) break;
         nb++;
      end
      chk("busy_len", 32'(nb), 32'd16);
      chk("lk_ready_after_init", 32'(s_lk_ready), 32'd1);
   endtask

   task automatic preload(input logic [1:0] fill, input int sel, input logic [1:0] v);
      for (int i = 0; i < N; i++) begin
         pre_vals[i] = (i == sel) ? v : fill;
         mram[i]     = pre_vals[i];
      end
      pre_en = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      pre_en = 1'b0;
   endtask

   // Shift a chosen direction into the GHR: ram[0] predicts taken, ram[1] not-taken.
   task automatic push_bit(input logic b);
      step(1'b1, 11'(4'(b ? 0 : 1) ^ m_ghr), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, b);
   endtask

   initial begin
      do_reset();
      run_init();

      // lookup pc 5, GHR 0, counter 10 -> predicted taken
      preload(2'b01, 5, 2'b10);
      step(1'b1, 11'h005, 1'b0, 1'b0);
      chk("lk5_idx", 32'(s_idx), 32'd5);
      chk("lk5_we", 32'(s_we), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("lk5_pred", 32'(s_pred_taken), 32'd1);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("rs_taken_wdata", 32'(s_wdata), 32'd3);
      chk("rs_taken_idx", 32'(s_idx), 32'd5);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("rs_taken_nomisp", 32'(s_misp), 32'd0);

      // same entry, resolved not-taken -> write 01 and mispredict
      preload(2'b01, 5, 2'b10);
      step(1'b1, 11'(4'd5 ^ m_ghr), 1'b0, 1'b0);
      chk("lk_ghr1_idx", 32'(s_idx), 32'd5);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("rs_nt_wdata", 32'(s_wdata), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("rs_nt_misp", 32'(s_misp), 32'd1);
      chk("rs_nt_empty", 32'(s_rs_ready), 32'd0);

      // build GHR=1010, snapshot it in an entry, then mispredict it taken
      preload(2'b01, 0, 2'b10);
      push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
      step(1'b1, 11'(4'd1 ^ m_ghr), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 11'h3a7, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 11'h000, 1'b0, 1'b0);
      chk("ghr_recover_idx", 32'(s_idx), 32'd5);
      chk("ghr_recover_flush", 32'(s_rs_ready), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);

      // fill to DEPTH, then free one slot
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 11'($urandom_range(0, 2047)), 1'b0, 1'b0);
         step(1'b0, '0, 1'b0, 1'b0);
      end
      step(1'b1, 11'h123, 1'b0, 1'b0);
      chk("full_lk_ready", 32'(s_lk_ready), 32'd0);
      step(1'b0, '0, 1'b1, q[0].pred);
      step(1'b1, 11'h123, 1'b0, 1'b0);
      chk("after_pop_lk_ready", 32'(s_lk_ready), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0);

      // lookup and resolve together: resolve wins
      step(1'b1, 11'h055, 1'b1, q[0].pred);
      chk("both_we", 32'(s_we), 32'd1);
      chk("both_lk_stall", 32'(s_lk_ready), 32'd0);
      step(1'b1, 11'h055, 1'b0, 1'b0);
      chk("both_lk_next", 32'(s_lk_ready), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0);

      for (int i = 0; i < 2500; i++)
         step(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // reset during RESP discards the response; reset mid-INIT restarts the sweep
      for (int i = 0; i < 10 && !(q.size() < DEPTH && !resp_pend && init_cnt >= N); i++)
         step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 11'h2f1, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
      do_reset();
      run_init();
      for (int i = 0; i < 800; i++)
         step(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
